// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the single-cycle core's load/store path to a word-addressed data
//   memory. One access is in flight at a time, and the core is stalled until
//   that access completes. Byte and half accesses become word-aligned
//   requests with byte enables. Returned load data is shifted into place and
//   then sign- or zero-extended. Misaligned requests are rejected with a
//   one-cycle pulse. Reads that never return are ended by a timeout, which
//   pulses bus_error.
//
// Ports
//   clk, reset                 clock, async active-low reset
//   req_*                      core request (valid, we, size, unsigned, addr, wdata)
//   stall                      hold PC / instruction this cycle
//   load_data, load_valid      formatted load result, 1-cycle pulse
//   misaligned, bus_error      1-cycle fault pulses
//   mem_req/we/addr/wdata/be   memory request, held stable until mem_ready
//   mem_ready                  memory accepts the request
//   mem_rvalid, mem_rdata      read response
module load_store_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misaligned,
   output logic        bus_error,
   output logic        mem_req,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state, state_nxt;
   logic        we_q, uns_q, err_q;
   logic [1:0]  size_q, off_q;
   logic [31:0] cnt;
   logic        mis, accept, tmo_hit, capture;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;

   // Shift the addressed lane down to bit 0, then extend. Size 11 is a word.
   function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] size,
                                            input logic uns, input logic [1:0] off);
      logic [31:0] x;
      x = d >> {off, 3'b000};
      case (size)
         2'b00:   fmt_load = uns ? {24'd0, x[7:0]}  : {{24{x[7]}}, x[7:0]};
         2'b01:   fmt_load = uns ? {16'd0, x[15:0]} : {{16{x[15]}}, x[15:0]};
         default: fmt_load = d;
      endcase
   endfunction

   // Request decode and store formatting, all taken from the live request in IDLE
   always_comb begin
      mis = req_valid && ((req_size == 2'b01 && req_addr[0]) ||
                          (req_size[1] && req_addr[1:0] != 2'b00));
      accept = (state == IDLE) && req_valid && !mis;
      be_nxt    = 4'hF;
      wdata_nxt = req_wdata;
      if (req_we) begin
         case (req_size)
            2'b00: begin
               be_nxt    = 4'b0001 << req_addr[1:0];
               wdata_nxt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
               be_nxt    = 4'b0011 << req_addr[1:0];
               wdata_nxt = {2{req_wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // The timeout fires on the cycle the count reaches TIMEOUT, so there are
   // exactly TIMEOUT WAIT cycles. A TIMEOUT of 0 means wait forever.
   assign tmo_hit = (TIMEOUT != 0) && (cnt == TIMEOUT - 32'd1);
   assign capture = !we_q && mem_rvalid &&
                    ((state == REQ && mem_ready) || state == WAIT);

   always_comb begin
      state_nxt  = state;
      stall      = 1'b0;
      misaligned = 1'b0;
      mem_req    = 1'b0;
      load_valid = 1'b0;
      bus_error  = 1'b0;
      case (state)
         IDLE: begin
            misaligned = (state == IDLE) && mis;
            stall      = accept;
            if (accept) state_nxt = REQ;
         end
         REQ: begin
            mem_req = 1'b1;
            stall   = 1'b1;
            if (mem_ready) state_nxt = (we_q || mem_rvalid) ? DONE : WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            if (mem_rvalid || tmo_hit) state_nxt = DONE;
         end
         DONE: begin
            // The core retires the instruction at this edge. A req_valid seen
            // here still belongs to that same instruction, so it is ignored.
            load_valid = !we_q;
            bus_error  = err_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         err_q     <= 1'b0;
         size_q    <= 2'b00;
         off_q     <= 2'b00;
         cnt       <= 32'd0;
         load_data <= 32'd0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_be    <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= (state == WAIT) ? cnt + 32'd1 : 32'd0;
         if (accept) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            off_q     <= req_addr[1:0];
            err_q     <= 1'b0;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= be_nxt;
            mem_wdata <= wdata_nxt;
         end
         if (capture) begin
            load_data <= fmt_load(mem_rdata, size_q, uns_q, off_q);
         end else if (state == WAIT && tmo_hit) begin
            load_data <= 32'd0;
            err_q     <= 1'b1;
         end
      end
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle core's execute/writeback path and the data memory, replacing the core's direct data-memory connection.
- Accepts one load or store per instruction from the core and stalls the core until the access completes.
- Formats byte, halfword and word accesses into word-aligned memory requests with byte enables, and aligns and extends returned load data for register writeback.
- Detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, number of WAIT cycles without mem_rvalid before bus_error; 0 disables the timeout.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  core presents a memory instruction this cycle.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
req_unsigned  input  1  zero-extend loads (LBU/LHU).
req_addr  input  32  byte address.
req_wdata  input  32  store data; the low bits are used for byte and half accesses.
stall  output  1  hold PC and instruction this cycle.
load_data  output  32  aligned and extended load result; valid while load_valid is high.
load_valid  output  1  1-cycle pulse when a load completes.
misaligned  output  1  1-cycle pulse on a misaligned request.
bus_error  output  1  1-cycle pulse on timeout.
mem_req  output  1  memory request valid.
mem_ready  input  1  memory accepts the request this cycle.
mem_we  output  1  write request.
mem_addr  output  32  word address: {req_addr[31:2], 2'b00}.
mem_wdata  output  32  replicated store data.
mem_be  output  4  byte enables.
mem_rvalid  input  1  read data valid.
mem_rdata  input  32  read data.

Behaviour:
- Reset (async, reset=0): state=IDLE. stall, load_data, load_valid, misaligned, bus_error, mem_req, mem_we, mem_addr, mem_wdata, mem_be and the timeout counter are all 0. mem_req drops immediately, even mid-transaction.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Misaligned request (req_valid and half with addr[0]=1, or word with addr[1:0]!=0): misaligned=1 combinationally; stall=0; no mem_req; stay in IDLE.
  - Aligned request (req_valid, not misaligned): stall=1 combinationally; register we, size, unsigned, addr[1:0], mem_addr, mem_be, mem_wdata; go to REQ.
- REQ:
  - mem_req=1; stall=1; mem_* outputs stable until accepted.
  - mem_ready=1 and store: go to DONE.
  - mem_ready=1 and load: go to DONE if mem_rvalid=1 in the same cycle (capture data); otherwise go to WAIT.
- WAIT:
  - mem_req=0; stall=1; counter increments each cycle.
  - mem_rvalid=1: capture formatted data into load_data, go to DONE.
  - counter reaches TIMEOUT (nonzero) with no mem_rvalid: load_data=0, bus_error pulses in DONE, go to DONE.
- DONE:
  - stall=0, so the core retires the instruction at this edge.
  - Loads: load_valid=1.
  - req_valid is ignored in DONE, since it is the same instruction. Next state IDLE; counter cleared.
- Store formatting (by registered addr[1:0]=o):
  - byte: mem_be = 4'b0001<<o; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_be = 4'b0011<<o; mem_wdata = {2{wdata[15:0]}}.
  - word: mem_be = 4'hF; mem_wdata = wdata.
- Load formatting:
  - x = mem_rdata >> (8*o).
  - byte: 8 bits of x, sign- or zero-extended per req_unsigned.
  - half: 16 bits of x, sign- or zero-extended per req_unsigned.
  - word: mem_rdata unchanged.
  - mem_be for loads = 4'hF.
- Stray responses: mem_rvalid outside REQ/WAIT, including after a reset mid-transaction, is ignored.
- Throughput: minimum access latency is 2 stall cycles (IDLE, REQ) plus DONE; one outstanding transaction at a time.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, mem_ready=1 in REQ -> mem_addr 0x100, mem_be 4'hF, mem_wdata 0xDEADBEEF, mem_we=1; stall high in IDLE and REQ cycles, low in DONE; no load_valid.
- SH addr 0x102, wdata 0x1234ABCD -> mem_addr 0x100, mem_be 4'b1100, mem_wdata 0xABCDABCD.
- LB addr 0x103, mem_rdata 0x80FF0000 returned 2 cycles after accept -> load_valid pulse, load_data 0xFFFFFF80. Repeat as LBU -> 0x00000080. Repeat as LH addr 0x102 -> 0xFFFF80FF.
- LW addr 0x102 -> misaligned pulse for 1 cycle, stall=0, mem_req never asserted; a following aligned LW 0x104 proceeds normally.
- TIMEOUT=4, LW with no mem_rvalid -> after 4 WAIT cycles, DONE with bus_error=1, load_data=0, load_valid=1, stall=0; the next request is accepted.
- Reset asserted during WAIT, mem_rvalid pulsed after release -> all outputs 0 immediately on reset, state IDLE, the stray mem_rvalid produces no load_valid.
